// File: rtl/lm32_jtag_link.sv
// CPU-clock-domain end of the JTAG data register. Host commands arrive on
// reg_update in the jtck domain and drive the RX/TX byte channels and the break/reset requests.
module lm32_jtag_link #(
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       reg_update,
  input  logic [7:0] reg_q,
  input  logic [2:0] reg_addr_q,
  output logic [7:0] reg_d,
  output logic [2:0] reg_addr_d,
  input  logic [7:0] tx_data_i,
  input  logic       tx_we_i,
  output logic       tx_busy_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_i,
  output logic       break_o,
  output logic       reset_o
);

  localparam logic [2:0] CMD_RX_WRITE = 3'd1;
  localparam logic [2:0] CMD_TX_ACK   = 3'd2;
  localparam logic [2:0] CMD_CLR_OVR  = 3'd3;
  localparam logic [2:0] CMD_BREAK    = 3'd4;
  localparam logic [2:0] CMD_RESET    = 3'd5;
  localparam logic [7:0] RST_LOAD     = 8'(RESET_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   cmd_stb;
  logic                   do_rx_write, do_tx_ack, do_clr_ovr, do_break, do_reset;

  logic [7:0] tx_buf, rx_buf;
  logic       tx_full, rx_full, rx_overrun;
  logic [7:0] rst_cnt;

  // Flops reset to 1 so an update level already high at reset release is not seen as an edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], reg_update};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cmd_stb     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign do_rx_write = cmd_stb && (reg_addr_q == CMD_RX_WRITE);
  assign do_tx_ack   = cmd_stb && (reg_addr_q == CMD_TX_ACK);
  assign do_clr_ovr  = cmd_stb && (reg_addr_q == CMD_CLR_OVR);
  assign do_break    = cmd_stb && (reg_addr_q == CMD_BREAK);
  assign do_reset    = cmd_stb && (reg_addr_q == CMD_RESET);

  // An ack in the same cycle as a host write frees the slot, so the write lands without overrun.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_buf     <= 8'h00;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (do_rx_write) begin
        if (!rx_full || rx_ack_i) begin
          rx_buf  <= reg_q;
          rx_full <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ack_i) begin
        rx_full <= 1'b0;
      end
      if (do_clr_ovr) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
    end else begin
      if (tx_we_i && (!tx_full || do_tx_ack)) begin
        tx_buf  <= tx_data_i;
        tx_full <= 1'b1;
      end else if (do_tx_ack) begin
        tx_full <= 1'b0;
      end
    end
  end

  // A RESET during an active pulse reloads the counter, stretching the pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      break_o <= 1'b0;
      rst_cnt <= 8'h00;
    end else begin
      break_o <= do_break;
      if (do_reset) begin
        rst_cnt <= RST_LOAD;
      end else if (rst_cnt != 8'h00) begin
        rst_cnt <= rst_cnt - 8'h01;
      end
    end
  end

  assign reset_o    = (rst_cnt != 8'h00);
  assign reg_d      = tx_buf;
  assign reg_addr_d = {rx_overrun, rx_full, tx_full};
  assign tx_busy_o  = tx_full;
  assign rx_data_o  = rx_buf;
  assign rx_valid_o = rx_full;

endmodule

// File: tb/tb_lm32_jtag_link.sv
// Directed bench for lm32_jtag_link: a behavioural link model checked every cycle,
// plus literal expectations taken from the host/CPU scenarios.
module tb_lm32_jtag_link;

  localparam int SYNC = 2;
  localparam int RCYC = 16;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       reg_update = 1'b1;
  logic [7:0] reg_q = 8'hFF;
  logic [2:0] reg_addr_q = 3'd1;
  logic [7:0] reg_d;
  logic [2:0] reg_addr_d;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_we_i = 1'b0;
  logic       tx_busy_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ack_i = 1'b0;
  logic       break_o;
  logic       reset_o;

  int total = 0;
  int bad = 0;

  lm32_jtag_link #(.SYNC_STAGES(SYNC), .RESET_CYCLES(RCYC)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .reg_update(reg_update), .reg_q(reg_q),
    .reg_addr_q(reg_addr_q), .reg_d(reg_d), .reg_addr_d(reg_addr_d),
    .tx_data_i(tx_data_i), .tx_we_i(tx_we_i), .tx_busy_o(tx_busy_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ack_i(rx_ack_i),
    .break_o(break_o), .reset_o(reset_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a reg_update rise sampled at edge n is acted on at edge n+SYNC.
  logic [7:0] m_rx_buf, m_tx_buf;
  bit         m_rx_full, m_tx_full, m_ovr, m_break;
  int         m_rst_left;
  bit         samp[SYNC+1];
  bit         fire, rx_free, tx_room;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_rx_buf = 0; m_tx_buf = 0;
      m_rx_full = 0; m_tx_full = 0; m_ovr = 0; m_break = 0;
      m_rst_left = 0;
      for (int i = 0; i <= SYNC; i++) samp[i] = 1;
    end else begin
      fire = samp[SYNC-1] && !samp[SYNC];
      rx_free = !m_rx_full || rx_ack_i;
      if (fire && reg_addr_q == 3'd1) begin
        if (rx_free) begin m_rx_buf = reg_q; m_rx_full = 1; end
        else m_ovr = 1;
      end else if (rx_ack_i) m_rx_full = 0;
      if (fire && reg_addr_q == 3'd3) m_ovr = 0;
      tx_room = !m_tx_full || (fire && reg_addr_q == 3'd2);
      if (tx_we_i && tx_room) begin m_tx_buf = tx_data_i; m_tx_full = 1; end
      else if (fire && reg_addr_q == 3'd2) m_tx_full = 0;
      m_break = fire && reg_addr_q == 3'd4;
      if (fire && reg_addr_q == 3'd5) m_rst_left = RCYC;
      else if (m_rst_left > 0) m_rst_left--;
      for (int i = SYNC; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = reg_update;
    end
  end

  always @(negedge clk_i) begin
    if (rstn_i) begin
      check_output("rx_data", rx_data_o, m_rx_buf);
      check_output("rx_valid", rx_valid_o, m_rx_full);
      check_output("tx_busy", tx_busy_o, m_tx_full);
      check_output("reg_d", reg_d, m_tx_buf);
      check_output("reg_addr_d", reg_addr_d, {m_ovr, m_rx_full, m_tx_full});
      check_output("break", break_o, m_break);
      check_output("reset_o", reset_o, m_rst_left > 0);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_raise(input logic [2:0] a, input logic [7:0] q);
    reg_addr_q = a;
    reg_q = q;
    reg_update = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [2:0] a, input logic [7:0] q);
    host_raise(a, q);
    repeat (4) step();
    reg_update = 1'b0;
    repeat (4) step();
  endtask

  int cnt, first, last;

  initial begin
    // 1: reset release with update already high
    repeat (3) step();
    rstn_i = 1'b1;
    repeat (6) step();
    check_output("t1_rx_valid", rx_valid_o, 1'b0);
    check_output("t1_status", reg_addr_d, 3'b000);
    check_output("t1_reg_d", reg_d, 8'h00);
    reg_update = 1'b0;
    repeat (4) step();

    // 2: single RX write and ack
    host_raise(3'd1, 8'hA5);
    step(); check_output("t2_e1_valid", rx_valid_o, 1'b0);
    step(); check_output("t2_e2_valid", rx_valid_o, 1'b0);
    step();
    check_output("t2_e3_valid", rx_valid_o, 1'b1);
    check_output("t2_data", rx_data_o, 8'hA5);
    check_output("t2_status", reg_addr_d, 3'b010);
    repeat (2) step();
    reg_update = 1'b0;
    rx_ack_i = 1'b1; step(); rx_ack_i = 1'b0;
    check_output("t2_acked", rx_valid_o, 1'b0);
    repeat (3) step();

    // 3: overrun and clear
    apply_stimulus(3'd1, 8'h11);
    apply_stimulus(3'd1, 8'h22);
    check_output("t3_data", rx_data_o, 8'h11);
    check_output("t3_status_ovr", reg_addr_d, 3'b110);
    apply_stimulus(3'd3, 8'h00);
    check_output("t3_status_clr", reg_addr_d, 3'b010);
    check_output("t3_data_kept", rx_data_o, 8'h11);
    rx_ack_i = 1'b1; step(); rx_ack_i = 1'b0;
    check_output("t3_acked", rx_valid_o, 1'b0);

    // 4: TX channel
    tx_data_i = 8'h3C; tx_we_i = 1'b1; step(); tx_we_i = 1'b0;
    check_output("t4_busy", tx_busy_o, 1'b1);
    check_output("t4_reg_d", reg_d, 8'h3C);
    tx_data_i = 8'h55; tx_we_i = 1'b1; step(); tx_we_i = 1'b0;
    check_output("t4_ignored", reg_d, 8'h3C);
    host_raise(3'd2, 8'h00);
    step(); step();
    tx_data_i = 8'h77; tx_we_i = 1'b1; step(); tx_we_i = 1'b0;
    check_output("t4_ack_we_busy", tx_busy_o, 1'b1);
    check_output("t4_ack_we_data", reg_d, 8'h77);
    repeat (2) step();
    reg_update = 1'b0;
    repeat (4) step();
    check_output("t4_status", reg_addr_d, 3'b001);

    // 5: break pulse, then stretched reset pulse
    host_raise(3'd4, 8'h00);
    cnt = 0; first = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (break_o) begin cnt++; first = i; end
      if (i == 4) reg_update = 1'b0;
    end
    check_output("t5_break_len", cnt, 1);
    check_output("t5_break_at", first, 3);
    host_raise(3'd5, 8'h00);
    cnt = 0; first = -1; last = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (reset_o) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (i == 4 || i == 14) reg_update = 1'b0;
      if (i == 10) reg_update = 1'b1;
    end
    check_output("t5_reset_len", cnt, 26);
    check_output("t5_reset_first", first, 3);
    check_output("t5_reset_last", last, 28);

    // 6: write coinciding with ack while full, then async reset mid-pulse
    apply_stimulus(3'd1, 8'h40);
    check_output("t6_pre_data", rx_data_o, 8'h40);
    host_raise(3'd1, 8'h99);
    step(); step();
    rx_ack_i = 1'b1; step(); rx_ack_i = 1'b0;
    check_output("t6_valid", rx_valid_o, 1'b1);
    check_output("t6_data", rx_data_o, 8'h99);
    check_output("t6_status", reg_addr_d, 3'b011);
    repeat (2) step();
    reg_update = 1'b0;
    repeat (4) step();
    host_raise(3'd5, 8'h00);
    repeat (5) step();
    check_output("t6_reset_on", reset_o, 1'b1);
    reg_update = 1'b0;
    rstn_i = 1'b0;
    #1;
    check_output("t6_async_reset_o", reset_o, 1'b0);
    check_output("t6_async_status", reg_addr_d, 3'b000);
    check_output("t6_async_rx_valid", rx_valid_o, 1'b0);
    check_output("t6_async_tx_busy", tx_busy_o, 1'b0);
    check_output("t6_async_reg_d", reg_d, 8'h00);
    check_output("t6_async_rx_data", rx_data_o, 8'h00);
    step();
    rstn_i = 1'b1;
    repeat (20) step();
    check_output("t6_after_reset_o", reset_o, 1'b0);
    check_output("t6_after_status", reg_addr_d, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lm32_jtag_link.md
Name: lm32_jtag_link

Overview:
- CPU-clock-domain endpoint of the JTAG data register.
- Receives the latched JTAG register (byte, command, update strobe) in the jtck domain and synchronises it into clk_i.
- Decodes host commands into a one-byte host-to-CPU (RX) channel, a one-byte CPU-to-host (TX) channel, and break/reset requests.
- Drives the capture value that the JTAG shift register loads on its next capture, which reports TX data and link status to the host.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on reg_update; legal range 2..4.
RESET_CYCLES, 16, length in clk_i cycles of the reset_o pulse; legal range 1..255.

Ports:
clk_i  in  1  CPU clock.
rstn_i  in  1  Asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
reg_update  in  1  Update strobe from the JTAG register, jtck domain.
reg_q  in  8  Latched host data byte; stable while reg_update is high.
reg_addr_q  in  3  Latched host command; stable while reg_update is high.
reg_d  out  8  Capture data for the JTAG register, equal to tx_buf.
reg_addr_d  out  3  Capture status: {rx_overrun, rx_full, tx_full} (bit2..bit0).
tx_data_i  in  8  CPU byte to send to the host.
tx_we_i  in  1  CPU write strobe for tx_data_i.
tx_busy_o  out  1  TX buffer occupied; equal to tx_full.
rx_data_o  out  8  Byte received from the host.
rx_valid_o  out  1  RX buffer occupied; equal to rx_full.
rx_ack_i  in  1  CPU has consumed rx_data_o.
break_o  out  1  One-cycle debug break request.
reset_o  out  1  CPU reset request, high for RESET_CYCLES cycles.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - tx_buf, rx_buf = 0; tx_full, rx_full, rx_overrun = 0; break_o, reset_o = 0; reset counter = 0.
  - All synchroniser flops and the edge-history flop reset to 1. A reg_update level already high at reset release therefore produces no command.
- Synchroniser and strobe:
  - reg_update passes through SYNC_STAGES flops, then a history flop.
  - cmd_stb = sync_out & ~history.
  - With default parameters, cmd_stb is high in the 3rd clk_i cycle after reg_update rises (setup met).
  - reg_q and reg_addr_q are sampled in the cmd_stb cycle. The host holds them stable for at least SYNC_STAGES+2 clk_i cycles.
- Commands (reg_addr_q, acted on only when cmd_stb = 1):
  - 0 NOP: no effect. Used by the host to poll status.
  - 1 RX_WRITE:
    - rx_full = 0: rx_buf <= reg_q; rx_full <= 1.
    - rx_full = 1: byte dropped; rx_overrun <= 1.
  - 2 TX_ACK: tx_full <= 0. No effect if already empty.
  - 3 CLR_OVR: rx_overrun <= 0.
  - 4 BREAK: break_o = 1 for exactly the next cycle.
  - 5 RESET: reset_o <= 1; counter loads RESET_CYCLES. A RESET received while the pulse is active reloads the counter (pulse extended).
  - 6, 7: ignored.
- CPU side:
  - rx_ack_i with rx_full = 1 clears rx_full. rx_ack_i with rx_full = 0 is ignored.
  - tx_we_i with tx_full = 0: tx_buf <= tx_data_i; tx_full <= 1.
  - tx_we_i with tx_full = 1: ignored; tx_buf unchanged.
- Simultaneous events, same cycle:
  - RX_WRITE + rx_ack_i with rx_full = 1: the buffer is freed and the new byte loads. rx_full stays 1; no overrun.
  - TX_ACK + tx_we_i with tx_full = 1: the new byte loads; tx_full stays 1.
  - CLR_OVR cannot coincide with RX_WRITE (one command per strobe).
- Reset counter:
  - Decrements while nonzero; reset_o = (counter != 0).
  - reset_o and rx_overrun are not affected by rx_ack_i or tx_we_i.
- Outputs:
  - reg_d and reg_addr_d are registered from the state flops; they change only on clk_i edges.
  - The host re-reads status after each update, so multi-bit skew into the jtck domain is acceptable.
- rstn_i asserted mid-pulse: reset_o drops immediately (asynchronously); pending bytes are lost.

Test Plan:
1. Reset release with reg_update held at 1 → no cmd_stb; rx_valid_o = 0, reg_addr_d = 3'b000, reg_d = 8'h00.
2. Host update with addr = 1, q = 8'hA5 → rx_valid_o = 1 and rx_data_o = 8'hA5 on the 3rd clk_i after the update edge; reg_addr_d = 3'b010. rx_ack_i → rx_valid_o = 0 next cycle.
3. Two RX_WRITEs (8'h11 then 8'h22) without ack → rx_data_o = 8'h11, reg_addr_d[2] = 1. CLR_OVR → reg_addr_d[2] = 0; rx_data_o still 8'h11.
4. tx_we_i with 8'h3C → tx_busy_o = 1, reg_d = 8'h3C. A second tx_we_i with 8'h55 is ignored. TX_ACK asserted together with tx_we_i of 8'h77 → tx_busy_o stays 1, reg_d = 8'h77.
5. BREAK command → break_o high for exactly 1 cycle. RESET command → reset_o high for exactly 16 cycles; a second RESET at cycle 10 extends the pulse to end 16 cycles after the second strobe.
6. RX_WRITE strobe coinciding with rx_ack_i while full → rx_full stays 1, rx_data_o = new byte, rx_overrun = 0. rstn_i pulsed low mid-reset_o → reset_o = 0 immediately, all flags 0.
